// File: rtl/comp_pkt_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : comp_pkt_arbiter
//  Description : Packet-granular round-robin arbiter that shares one
//                bit-plane compression encoder between NUM_CH requesters.
//                It grants whole packets and passes beats to the encoder
//                combinationally. Packet length is enforced at BEATS beats.
//                A tag FIFO records the owner of each packet in flight
//                through the encoder.
//  Ports       : clk, rst_n             - clock, async active-low reset
//                req_*                  - per-channel request streams
//                                         (channel k data at [k*DW +: DW])
//                cmp_data/valid/sop/eop - stream into the encoder
//                cmp_ready_i            - encoder input ready
//                cmp_out_valid/eop/ready_i - snoop of encoder output handshake
//                tag_o, tag_valid_o     - owner of packet at encoder output
//                busy_o                 - a packet transfer is in progress
//                err_len_o              - one-cycle pulse on length violation
//  Revision    : 1.0 - initial release
// ============================================================================
module comp_pkt_arbiter #(
    parameter int NUM_CH    = 4,
    parameter int DW        = 64,
    parameter int BEATS     = 16,
    parameter int TAG_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_CH*DW-1:0]      req_data_i,
    input  logic [NUM_CH-1:0]         req_valid_i,
    input  logic [NUM_CH-1:0]         req_sop_i,
    input  logic [NUM_CH-1:0]         req_eop_i,
    output logic [NUM_CH-1:0]         req_ready_o,
    output logic [DW-1:0]             cmp_data_o,
    output logic                      cmp_valid_o,
    output logic                      cmp_sop_o,
    output logic                      cmp_eop_o,
    input  logic                      cmp_ready_i,
    input  logic                      cmp_out_valid_i,
    input  logic                      cmp_out_eop_i,
    input  logic                      cmp_out_ready_i,
    output logic [$clog2(NUM_CH)-1:0] tag_o,
    output logic                      tag_valid_o,
    output logic                      busy_o,
    output logic                      err_len_o
);

    localparam int TW = $clog2(NUM_CH);
    localparam int CW = $clog2(BEATS);
    localparam int AW = $clog2(TAG_DEPTH);
    localparam logic [CW-1:0] C_LAST_BEAT = CW'(BEATS - 1);
    localparam logic [TW-1:0] C_RR_INIT   = TW'(NUM_CH - 1);
    localparam logic [AW:0]   C_FIFO_FULL = (AW+1)'(TAG_DEPTH);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    state_t        r_state;
    logic [TW-1:0] r_gnt;
    logic [TW-1:0] r_rr_ptr;
    logic [CW-1:0] r_beat_cnt;
    logic          r_err_len;
    logic [TW-1:0] r_tag_mem [TAG_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_tag_cnt;

    logic [DW-1:0]     w_ch_data [NUM_CH];
    logic [NUM_CH-1:0] w_elig;
    logic              w_any_elig;
    logic [TW-1:0]     w_sel;
    logic              w_full;
    logic              w_grant;
    logic              w_pop;
    logic              w_accept;
    logic              w_last;
    logic              w_src_eop;

    genvar gk;
    generate
        for (gk = 0; gk < NUM_CH; gk++) begin : g_unpack
            assign w_ch_data[gk] = req_data_i[gk*DW +: DW];
        end
    endgenerate

    // Only a sop head beat makes a channel eligible; a stray non-sop beat
    // is never granted.
    assign w_elig = req_valid_i & req_sop_i;

    // Round-robin search starting just after the last granted channel.
    always_comb begin : p_rr_search
        logic [TW-1:0] cand;
        cand       = '0;
        w_any_elig = 1'b0;
        w_sel      = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            cand = TW'((int'(r_rr_ptr) + i) % NUM_CH);
            if (!w_any_elig && w_elig[cand]) begin
                w_any_elig = 1'b1;
                w_sel      = cand;
            end
        end
    end

    assign w_last    = (r_beat_cnt == C_LAST_BEAT);
    assign w_src_eop = req_eop_i[r_gnt];

    // Zero-latency pass-through from the granted channel.
    always_comb begin
        req_ready_o = '0;
        cmp_data_o  = '0;
        cmp_valid_o = 1'b0;
        cmp_sop_o   = 1'b0;
        cmp_eop_o   = 1'b0;
        if (r_state == XFER) begin
            req_ready_o[r_gnt] = cmp_ready_i;
            cmp_data_o         = w_ch_data[r_gnt];
            cmp_valid_o        = req_valid_i[r_gnt];
            cmp_sop_o          = (r_beat_cnt == '0);
            // A missing source eop is forced on the last allowed beat.
            cmp_eop_o          = w_src_eop || w_last;
        end
    end

    assign w_accept = cmp_valid_o && cmp_ready_i;
    // Full uses the registered count, so a same-cycle pop cannot unblock.
    assign w_full   = (r_tag_cnt == C_FIFO_FULL);
    assign w_grant  = (r_state == IDLE) && w_any_elig && !w_full;
    assign w_pop    = cmp_out_valid_i && cmp_out_ready_i && cmp_out_eop_i &&
                      (r_tag_cnt != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_gnt      <= '0;
            r_rr_ptr   <= C_RR_INIT;
            r_beat_cnt <= '0;
            r_err_len  <= 1'b0;
        end else begin
            r_err_len <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_grant) begin
                        r_gnt      <= w_sel;
                        r_rr_ptr   <= w_sel;
                        r_beat_cnt <= '0;
                        r_state    <= XFER;
                    end
                end
                XFER: begin
                    if (w_accept) begin
                        if (cmp_eop_o) begin
                            r_beat_cnt <= '0;
                            r_state    <= IDLE;
                            // Flags both early eop and forced truncation.
                            r_err_len  <= (w_src_eop != w_last);
                        end else begin
                            r_beat_cnt <= r_beat_cnt + CW'(1);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Tag FIFO: one entry per granted packet, retired on encoder output eop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_tag_cnt <= '0;
            for (int i = 0; i < TAG_DEPTH; i++) begin
                r_tag_mem[i] <= '0;
            end
        end else begin
            if (w_grant) begin
                r_tag_mem[r_wr_ptr] <= w_sel;
                r_wr_ptr            <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_grant, w_pop})
                2'b10:   r_tag_cnt <= r_tag_cnt + (AW+1)'(1);
                2'b01:   r_tag_cnt <= r_tag_cnt - (AW+1)'(1);
                default: r_tag_cnt <= r_tag_cnt;
            endcase
        end
    end

    assign tag_o       = r_tag_mem[r_rd_ptr];
    assign tag_valid_o = (r_tag_cnt != '0);
    assign busy_o      = (r_state == XFER);
    assign err_len_o   = r_err_len;

endmodule
`default_nettype wire

// File: tb/tb_comp_pkt_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_comp_pkt_arbiter
//  Description : Self-checking bench for comp_pkt_arbiter. Sources are beat
//                queues per channel; a packet-level reference model predicts
//                grants, beat positions, length errors and tag FIFO contents.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_comp_pkt_arbiter;

    localparam int NUM_CH    = 4;
    localparam int DW        = 64;
    localparam int BEATS     = 16;
    localparam int TAG_DEPTH = 4;
    localparam int TW        = 2;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b1;
    logic [NUM_CH*DW-1:0] req_data_i;
    logic [NUM_CH-1:0]    req_valid_i;
    logic [NUM_CH-1:0]    req_sop_i;
    logic [NUM_CH-1:0]    req_eop_i;
    logic [NUM_CH-1:0]    req_ready_o;
    logic [DW-1:0]        cmp_data_o;
    logic                 cmp_valid_o;
    logic                 cmp_sop_o;
    logic                 cmp_eop_o;
    logic                 cmp_ready_i;
    logic                 cmp_out_valid_i;
    logic                 cmp_out_eop_i;
    logic                 cmp_out_ready_i;
    logic [TW-1:0]        tag_o;
    logic                 tag_valid_o;
    logic                 busy_o;
    logic                 err_len_o;

    comp_pkt_arbiter #(
        .NUM_CH(NUM_CH), .DW(DW), .BEATS(BEATS), .TAG_DEPTH(TAG_DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_data_i(req_data_i), .req_valid_i(req_valid_i),
        .req_sop_i(req_sop_i), .req_eop_i(req_eop_i), .req_ready_o(req_ready_o),
        .cmp_data_o(cmp_data_o), .cmp_valid_o(cmp_valid_o),
        .cmp_sop_o(cmp_sop_o), .cmp_eop_o(cmp_eop_o), .cmp_ready_i(cmp_ready_i),
        .cmp_out_valid_i(cmp_out_valid_i), .cmp_out_eop_i(cmp_out_eop_i),
        .cmp_out_ready_i(cmp_out_ready_i),
        .tag_o(tag_o), .tag_valid_o(tag_valid_o), .busy_o(busy_o),
        .err_len_o(err_len_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          sop;
        logic          eop;
    } beat_t;

    beat_t         srcq [NUM_CH][$];
    int            tagq[$];
    int            dut_gnts[$];
    logic [DW-1:0] sent[$];
    logic [DW-1:0] rx[$];

    int  n_assert = 0;
    int  n_fail   = 0;
    int  dut_err_cnt = 0;
    bit  m_busy;
    int  m_gnt, m_rr, m_cnt;
    bit  m_err;
    bit  prev_busy;
    int  rdy_mode;
    bit  tog;
    bit  out_rand;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic add_pkt(int ch, int len, bit eop_last, bit rnd, logic [63:0] base);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.d   = rnd ? {$urandom, $urandom} : base + 64'(i);
            b.sop = (i == 0);
            b.eop = eop_last && (i == len - 1);
            srcq[ch].push_back(b);
            sent.push_back(b.d);
        end
    endtask

    function automatic bit src_pending();
        for (int k = 0; k < NUM_CH; k++) if (srcq[k].size() != 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic chk_reset_outs();
        chk("rst_req_ready", req_ready_o, 0);
        chk("rst_cmp_valid", cmp_valid_o, 0);
        chk("rst_cmp_sop", cmp_sop_o, 0);
        chk("rst_cmp_eop", cmp_eop_o, 0);
        chk("rst_cmp_data", cmp_data_o, 0);
        chk("rst_tag", tag_o, 0);
        chk("rst_tag_valid", tag_valid_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_err_len", err_len_o, 0);
    endtask

    // Called on a negedge; asserts reset immediately (possibly mid-packet).
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk_reset_outs();
        for (int k = 0; k < NUM_CH; k++) srcq[k].delete();
        tagq.delete(); dut_gnts.delete(); rx.delete(); sent.delete();
        m_busy = 0; m_gnt = 0; m_rr = NUM_CH - 1; m_cnt = 0; m_err = 0;
        prev_busy = 0; rdy_mode = 0; out_rand = 0; tog = 0;
        req_valid_i = '0; req_sop_i = '0; req_eop_i = '0; req_data_i = '0;
        cmp_ready_i = 1'b1;
        cmp_out_valid_i = 1'b0; cmp_out_eop_i = 1'b0; cmp_out_ready_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One clock cycle: drive at negedge, check, advance model, wait.
    task automatic step();
        logic [NUM_CH-1:0] e_rdy;
        logic              e_eop;
        int                pre, c;
        bit                pop, push, found;
        for (int k = 0; k < NUM_CH; k++) begin
            if (srcq[k].size() != 0) begin
                req_valid_i[k]          = 1'b1;
                req_data_i[k*DW +: DW]  = srcq[k][0].d;
                req_sop_i[k]            = srcq[k][0].sop;
                req_eop_i[k]            = srcq[k][0].eop;
            end else begin
                req_valid_i[k]          = 1'b0;
                req_data_i[k*DW +: DW]  = '0;
                req_sop_i[k]            = 1'b0;
                req_eop_i[k]            = 1'b0;
            end
        end
        case (rdy_mode)
            0:       cmp_ready_i = 1'b1;
            1:       begin tog = !tog; cmp_ready_i = tog; end
            default: cmp_ready_i = 1'($urandom_range(0, 1));
        endcase
        if (out_rand) begin
            cmp_out_valid_i = 1'($urandom_range(0, 1));
            cmp_out_eop_i   = 1'($urandom_range(0, 1));
            cmp_out_ready_i = 1'($urandom_range(0, 1));
        end
        #1;
        e_rdy = '0;
        e_eop = 1'b0;
        if (m_busy) begin
            e_rdy[m_gnt] = cmp_ready_i;
            e_eop = req_eop_i[m_gnt] || (m_cnt == BEATS - 1);
            chk("cmp_valid", cmp_valid_o, req_valid_i[m_gnt]);
            chk("cmp_data", cmp_data_o, req_data_i[m_gnt*DW +: DW]);
            chk("cmp_sop", cmp_sop_o, m_cnt == 0);
            chk("cmp_eop", cmp_eop_o, e_eop);
        end else begin
            chk("cmp_valid_idle", cmp_valid_o, 0);
        end
        chk("req_ready", req_ready_o, e_rdy);
        chk("busy", busy_o, m_busy);
        chk("err_len", err_len_o, m_err);
        chk("tag_valid", tag_valid_o, tagq.size() != 0);
        if (tagq.size() != 0) chk("tag", tag_o, tagq[0]);

        if (cmp_valid_o && cmp_ready_i) rx.push_back(cmp_data_o);
        if (err_len_o) dut_err_cnt++;
        if (busy_o && !prev_busy && cmp_ready_i)
            for (int k = 0; k < NUM_CH; k++) if (req_ready_o[k]) dut_gnts.push_back(k);
        prev_busy = busy_o;

        pre   = tagq.size();
        pop   = cmp_out_valid_i && cmp_out_ready_i && cmp_out_eop_i && (pre != 0);
        push  = 0;
        found = 0;
        m_err = 0;
        if (!m_busy) begin
            if (pre < TAG_DEPTH) begin
                for (int i = 1; i <= NUM_CH; i++) begin
                    c = (m_rr + i) % NUM_CH;
                    if (!found && req_valid_i[c] && req_sop_i[c]) begin
                        found = 1;
                        m_gnt = c;
                    end
                end
            end
            if (found) begin
                m_rr = m_gnt; push = 1; m_busy = 1; m_cnt = 0;
            end
        end else if (req_valid_i[m_gnt] && cmp_ready_i) begin
            if (e_eop) begin
                m_err  = req_eop_i[m_gnt] != (m_cnt == BEATS - 1);
                m_busy = 0;
                m_cnt  = 0;
            end else begin
                m_cnt++;
            end
        end
        if (pop) void'(tagq.pop_front());
        if (push) tagq.push_back(m_gnt);
        for (int k = 0; k < NUM_CH; k++)
            if (req_valid_i[k] && req_ready_o[k]) void'(srcq[k].pop_front());
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_until_idle(int max_cyc);
        int n = 0;
        while ((src_pending() || m_busy) && n < max_cyc) begin
            step();
            n++;
        end
        chk("idle_timeout", n < max_cyc, 1);
        step();
        step();
    endtask

    task automatic cmp_stream(string tag);
        chk({tag, "_count"}, rx.size(), sent.size());
        for (int i = 0; i < sent.size() && i < rx.size(); i++) chk(tag, rx[i], sent[i]);
    endtask

    initial begin
        int e0, n;
        req_valid_i = '0; req_sop_i = '0; req_eop_i = '0; req_data_i = '0;
        cmp_ready_i = 1'b1;
        cmp_out_valid_i = 1'b0; cmp_out_eop_i = 1'b0; cmp_out_ready_i = 1'b0;
        #2;
        do_reset();

        // Single channel, fixed data
        add_pkt(0, 16, 1, 0, 64'h1234567890123456);
        run_until_idle(60);
        cmp_stream("t1_data");
        chk("t1_tag", tag_o, 0);
        chk("t1_tag_valid", tag_valid_o, 1);
        chk("t1_no_err", dut_err_cnt, 0);

        // All channels continuously, tags retired every cycle
        do_reset();
        cmp_out_valid_i = 1'b1; cmp_out_eop_i = 1'b1; cmp_out_ready_i = 1'b1;
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < NUM_CH; k++) add_pkt(k, 16, 1, 1, 0);
        run_until_idle(300);
        chk("t2_beats", rx.size(), 8 * BEATS);
        chk("t2_ngrants", dut_gnts.size() >= 5, 1);
        if (dut_gnts.size() >= 5) begin
            chk("t2_order0", dut_gnts[0], 0);
            chk("t2_order1", dut_gnts[1], 1);
            chk("t2_order2", dut_gnts[2], 2);
            chk("t2_order3", dut_gnts[3], 3);
            chk("t2_order4", dut_gnts[4], 0);
        end

        // Backpressure on a ch2 packet
        do_reset();
        rdy_mode = 1;
        add_pkt(2, 16, 1, 1, 0);
        run_until_idle(80);
        cmp_stream("t3_data");

        // Length errors: early eop, then missing eop
        do_reset();
        e0 = dut_err_cnt;
        add_pkt(1, 10, 1, 1, 0);
        add_pkt(1, 16, 0, 1, 0);
        run_until_idle(80);
        cmp_stream("t4_data");
        chk("t4_err_pulses", dut_err_cnt - e0, 2);

        // Tag FIFO full blocks the 5th grant until one output eop
        do_reset();
        for (int k = 0; k < NUM_CH; k++) add_pkt(k, 16, 1, 1, 0);
        add_pkt(0, 16, 1, 1, 0);
        for (int i = 0; i < 80; i++) step();
        chk("t5_blocked_busy", busy_o, 0);
        chk("t5_blocked_grants", dut_gnts.size(), 4);
        cmp_out_valid_i = 1'b1; cmp_out_eop_i = 1'b1; cmp_out_ready_i = 1'b1;
        step();
        cmp_out_valid_i = 1'b0; cmp_out_eop_i = 1'b0; cmp_out_ready_i = 1'b0;
        run_until_idle(40);
        chk("t5_grants", dut_gnts.size(), 5);
        if (dut_gnts.size() == 5) begin
            chk("t5_gnt4", dut_gnts[4], 0);
            for (int j = 1; j < 5; j++) begin
                chk("t5_tag_seq", tag_o, dut_gnts[j]);
                cmp_out_valid_i = 1'b1; cmp_out_eop_i = 1'b1; cmp_out_ready_i = 1'b1;
                step();
                cmp_out_valid_i = 1'b0; cmp_out_eop_i = 1'b0; cmp_out_ready_i = 1'b0;
            end
        end
        chk("t5_drained", tag_valid_o, 0);

        // Reset at beat 7 of a ch1 packet
        do_reset();
        add_pkt(1, 16, 1, 1, 0);
        n = 0;
        while (!(m_busy && m_cnt == 7) && n < 40) begin
            step();
            n++;
        end
        chk("t6_reach_beat7", n < 40, 1);
        do_reset();
        add_pkt(1, 4, 1, 1, 0);
        add_pkt(0, 4, 1, 1, 0);
        run_until_idle(40);
        chk("t6_ngrants", dut_gnts.size(), 2);
        if (dut_gnts.size() == 2) begin
            chk("t6_first", dut_gnts[0], 0);
            chk("t6_second", dut_gnts[1], 1);
        end

        // Randomized traffic against the model
        do_reset();
        rdy_mode = 2;
        out_rand = 1;
        for (int r = 0; r < 3; r++)
            for (int k = 0; k < NUM_CH; k++) begin
                n = $urandom_range(1, BEATS);
                add_pkt(k, n, (n < BEATS) || ($urandom_range(0, 1) == 1), 1, 0);
            end
        run_until_idle(4000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
